// File: rtl/game_pkg.sv
// game_pkg: scan code set 2 constants, loader state/key types and the
// scan-code-to-hex-digit mapping shared by the keyboard input path.
package game_pkg;

    localparam int DIGITS_DEF = 4;

    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    // Indexed by hex digit value 0..F
    localparam logic [7:0] SC_DIGIT [16] = '{
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
        8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B
    };

    typedef enum logic [1:0] {ENTRY, FULL, DONE} loader_state_t;
    typedef enum logic [1:0] {KEY_NONE, KEY_DIGIT, KEY_ENTER, KEY_BKSP} key_t;

    function automatic logic [4:0] scan_to_nib(input logic [7:0] sc);
        logic [4:0] r;
        r = '0;
        for (int i = 0; i < 16; i++)
            if (sc == SC_DIGIT[i]) r = {1'b1, 4'(i)};
        return r;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 frame receiver with input synchronisers, clock glitch filter,
// odd-parity check and inter-edge timeout; emits one code per good frame.
module ps2_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    output logic [7:0] code,
    output logic       codeValid,
    output logic       frameErr
);

    localparam int FW = $clog2(FILTER_LEN);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [FW-1:0] FMAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    logic [1:0]    clk_s, dat_s;
    logic [FW-1:0] fcnt;
    logic [TW-1:0] tcnt;
    logic [3:0]    bitn;
    logic [7:0]    sh;
    logic          filt, busy, drain, change, fall, expire, d;

    always_comb begin
        d      = dat_s[1];
        change = clk_s[1] != filt && fcnt == FMAX;
        fall   = change && !clk_s[1];
        expire = (busy || drain) && !fall && tcnt == TMAX;
    end

    // drain swallows the stop bit that trails a parity failure, so one bad
    // frame reports exactly one error instead of a second start-bit error
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s     <= 2'b11;
            dat_s     <= 2'b11;
            filt      <= 1'b1;
            fcnt      <= '0;
            tcnt      <= '0;
            bitn      <= '0;
            sh        <= '0;
            busy      <= 1'b0;
            drain     <= 1'b0;
            code      <= '0;
            codeValid <= 1'b0;
            frameErr  <= 1'b0;
        end else begin
            clk_s     <= {clk_s[0], ps2Clk};
            dat_s     <= {dat_s[0], ps2Data};
            filt      <= change ? clk_s[1] : filt;
            fcnt      <= (clk_s[1] == filt || change) ? '0 : fcnt + 1'b1;
            tcnt      <= (fall || !(busy || drain)) ? '0 : tcnt + 1'b1;
            codeValid <= 1'b0;
            frameErr  <= 1'b0;
            if (expire) begin
                busy     <= 1'b0;
                drain    <= 1'b0;
                frameErr <= busy;
            end else if (fall) begin
                if (drain) begin
                    drain <= 1'b0;
                end else if (!busy) begin
                    busy     <= !d;
                    frameErr <= d;
                    bitn     <= 4'd1;
                end else begin
                    bitn <= bitn + 1'b1;
                    if (bitn <= 4'd8) begin
                        sh <= {d, sh[7:1]};
                    end else if (bitn == 4'd9) begin
                        if (!(^sh ^ d)) begin
                            busy     <= 1'b0;
                            drain    <= 1'b1;
                            frameErr <= 1'b1;
                        end
                    end else begin
                        busy      <= 1'b0;
                        codeValid <= d;
                        frameErr  <= !d;
                        code      <= sh;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/user_input_loader.sv
// user_input_loader: turns PS/2 keystrokes into a DIGITS-hex-digit answer
// with backspace and enter handling; ready holds until clear.
module user_input_loader
    import game_pkg::*;
#(
    parameter int DIGITS     = DIGITS_DEF,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 200000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ps2Clk,
    input  logic                ps2Data,
    input  logic                clear,
    output logic [4*DIGITS-1:0] userInt,
    output logic                ready,
    output logic [2:0]          digitCount,
    output logic                frameErr
);

    logic [7:0]          code;
    logic                code_valid, brk, ext;
    logic [4:0]          dec;
    key_t                key;
    loader_state_t       state, n_state;
    logic [4*DIGITS-1:0] val, n_val;
    logic [2:0]          cnt, n_cnt;

    ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) u_rx (
        .clk      (clk),
        .rst      (rst),
        .ps2Clk   (ps2Clk),
        .ps2Data  (ps2Data),
        .code     (code),
        .codeValid(code_valid),
        .frameErr (frameErr)
    );

    // Prefix codes never produce a key; the code after F0 is always dropped,
    // the code after E0 survives only as keypad Enter
    always_comb begin
        dec = scan_to_nib(code);
        key = (!code_valid || code == SC_BRK || code == SC_EXT || brk) ? KEY_NONE :
              ext                ? (code == SC_ENTER ? KEY_ENTER : KEY_NONE) :
              code == SC_ENTER   ? KEY_ENTER :
              code == SC_BKSP    ? KEY_BKSP :
              dec[4]             ? KEY_DIGIT : KEY_NONE;
    end

    always_ff @(posedge clk) begin
        if (rst || frameErr) begin
            brk <= 1'b0;
            ext <= 1'b0;
        end else if (code_valid) begin
            if (code == SC_BRK) begin
                brk <= 1'b1;
            end else if (code == SC_EXT) begin
                ext <= 1'b1;
            end else begin
                brk <= 1'b0;
                ext <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ENTRY;
            val   <= '0;
            cnt   <= '0;
        end else begin
            state <= n_state;
            val   <= n_val;
            cnt   <= n_cnt;
        end
    end

    always_comb begin
        n_state = state;
        n_val   = val;
        n_cnt   = cnt;
        if (clear) begin
            n_state = ENTRY;
            n_val   = '0;
            n_cnt   = '0;
        end else begin
            case (state)
                ENTRY: begin
                    if (key == KEY_DIGIT) begin
                        n_val   = {val[4*DIGITS-5:0], dec[3:0]};
                        n_cnt   = cnt + 1'b1;
                        n_state = cnt == 3'(DIGITS - 1) ? FULL : ENTRY;
                    end else if (key == KEY_BKSP && cnt != 3'd0) begin
                        n_val = val >> 4;
                        n_cnt = cnt - 1'b1;
                    end
                end
                FULL: begin
                    if (key == KEY_BKSP) begin
                        n_val   = val >> 4;
                        n_cnt   = 3'(DIGITS - 1);
                        n_state = ENTRY;
                    end else if (key == KEY_ENTER) begin
                        n_state = DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        userInt    = val;
        digitCount = cnt;
        ready      = state == DONE;
    end

endmodule

// File: tb/tb_user_input_loader.sv
// tb_user_input_loader: directed PS/2 frame stimulus against hand-computed
// answer values, counts, ready and frame-error pulses.
module tb_user_input_loader;

    localparam int HALF = 20;
    localparam int TOUT = 2000;

    logic        clk = 1'b0;
    logic        rst, ps2Clk, ps2Data, clear;
    logic [15:0] userInt;
    logic        ready, frameErr;
    logic [2:0]  digitCount;
    int          tests = 0;
    int          fails = 0;
    int          errs  = 0;
    int          e0;

    user_input_loader #(.DIGITS(4), .FILTER_LEN(8), .TIMEOUT(TOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2Clk    (ps2Clk),
        .ps2Data   (ps2Data),
        .clear     (clear),
        .userInt   (userInt),
        .ready     (ready),
        .digitCount(digitCount),
        .frameErr  (frameErr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (frameErr) errs++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [10:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            ps2Data = w[i];
            wait_cyc(HALF);
            ps2Clk = 1'b0;
            wait_cyc(HALF);
            ps2Clk = 1'b1;
        end
        ps2Data = 1'b1;
        wait_cyc(3 * HALF);
    endtask

    task automatic send(input logic [7:0] b, input logic bad);
        send_bits({1'b1, (~(^b)) ^ bad, b, 1'b0}, 11);
    endtask

    task automatic key(input logic [7:0] b);
        send(b, 1'b0);
        send(8'hF0, 1'b0);
        send(b, 1'b0);
    endtask

    task automatic expect_out(input string tag, input logic [15:0] v, input logic [2:0] c, input logic r);
        check({tag, ".userInt"}, 32'(userInt), 32'(v));
        check({tag, ".count"}, 32'(digitCount), 32'(c));
        check({tag, ".ready"}, 32'(ready), 32'(r));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; ps2Clk = 1'b1; ps2Data = 1'b1; clear = 1'b0;
        wait_cyc(5);
        rst = 1'b0;
        wait_cyc(2);
        expect_out("reset", 16'h0000, 3'd0, 1'b0);
        check("reset.frameErr", 32'(frameErr), 32'd0);

        key(8'h16); key(8'h1C); key(8'h26); key(8'h2B);
        expect_out("basic4", 16'h1A3F, 3'd4, 1'b0);
        key(8'h5A);
        expect_out("basic_enter", 16'h1A3F, 3'd4, 1'b1);
        check("basic.errs", 32'(errs), 32'd0);

        send(8'h45, 1'b0);
        expect_out("done_frozen", 16'h1A3F, 3'd4, 1'b1);

        fork
            send(8'h2E, 1'b0);
            begin
                int k;
                k = 0;
                while (!dut.u_rx.codeValid && k < 2000) begin
                    @(negedge clk);
                    k++;
                end
                check("coll.seen", 32'(k < 2000), 32'd1);
                clear = 1'b1;
                @(negedge clk);
                clear = 1'b0;
            end
        join
        expect_out("collision", 16'h0000, 3'd0, 1'b0);

        send(8'h3D, 1'b0); send(8'h1E, 1'b0); send(8'h66, 1'b0);
        send(8'h46, 1'b0); send(8'h5A, 1'b0);
        expect_out("bksp", 16'h0079, 3'd2, 1'b0);
        send(8'h45, 1'b0); send(8'h45, 1'b0);
        expect_out("bksp_full", 16'h7900, 3'd4, 1'b0);
        send(8'h5A, 1'b0);
        expect_out("bksp_enter", 16'h7900, 3'd4, 1'b1);

        clear = 1'b1;
        wait_cyc(1);
        clear = 1'b0;
        wait_cyc(1);
        expect_out("clear", 16'h0000, 3'd0, 1'b0);
        send(8'h66, 1'b0);
        expect_out("bksp_empty", 16'h0000, 3'd0, 1'b0);

        e0 = errs;
        send(8'h16, 1'b1);
        check("parity.pulse", 32'(errs - e0), 32'd1);
        expect_out("parity", 16'h0000, 3'd0, 1'b0);
        send(8'h16, 1'b0);
        expect_out("after_parity", 16'h0001, 3'd1, 1'b0);
        check("after_parity.pulse", 32'(errs - e0), 32'd1);

        e0 = errs;
        send_bits({1'b1, 1'b0, 8'h45, 1'b0}, 5);
        check("timeout.early", 32'(errs - e0), 32'd0);
        wait_cyc(TOUT + 100);
        check("timeout.pulse", 32'(errs - e0), 32'd1);
        send(8'h45, 1'b0);
        expect_out("after_timeout", 16'h0010, 3'd2, 1'b0);

        send(8'hF0, 1'b0); send(8'h16, 1'b0);
        expect_out("release", 16'h0010, 3'd2, 1'b0);
        send(8'h2E, 1'b0); send(8'h36, 1'b0);
        expect_out("fill", 16'h1056, 3'd4, 1'b0);
        send(8'hE0, 1'b0); send(8'h66, 1'b0);
        expect_out("ext_drop", 16'h1056, 3'd4, 1'b0);
        send(8'h66, 1'b0);
        expect_out("full_bksp", 16'h0105, 3'd3, 1'b0);
        send(8'h36, 1'b0);
        send(8'hE0, 1'b0); send(8'h5A, 1'b0);
        expect_out("kp_enter", 16'h1056, 3'd4, 1'b1);
        check("final.errs", 32'(errs - e0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
